axi_rd_dma: RTL and testbench

- AXI read master sitting directly upstream of axi_dram_model. It drives the model's AR channel and consumes its R channel.
- Takes one command (byte base address plus word count) and splits it into INCR bursts of 4-byte beats.
- Bursts never exceed MAX_BURST beats and never cross a 4 KB boundary.
- Returned data is forwarded on a valid/ready stream to the compute-side buffer, with a last marker on the final word of the command.

---
 rtl/axi_rd_dma.sv | 156 +++++++++++++++
 tb/tb_axi_rd_dma.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_dma.sv
// AXI read DMA: splits a word-count command into 4 KB-safe INCR bursts and streams the data out.
// Optional perf counters (perf_cycles, perf_stall) are enabled with `define AXI_RD_DMA_PERF_EN.
module axi_rd_dma #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef AXI_RD_DMA_PERF_EN
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rvalid,
  input  logic              m_axi_rlast,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_DATA, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [8:0]        beat_cnt;

  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  next_rem;
  logic              beat;

  // Burst length limited by remaining words, MAX_BURST and the words left before the next 4 KB page.
  function automatic logic [8:0] calc_blen(input logic [11:0] page_off, input logic [LEN_W-1:0] rem);
    int unsigned room;
    int unsigned b;
    room = (32'd4096 - {20'd0, page_off}) >> 2;
    b    = 32'(rem);
    if (b > 32'(MAX_BURST)) b = 32'(MAX_BURST);
    if (b > room) b = room;
    return 9'(b);
  endfunction

  assign cmd_base  = cmd_addr & ~ADDR_W'(3);
  assign next_addr = addr_q + ADDR_W'(4);
  assign next_rem  = rem_q - LEN_W'(1);
  assign beat      = (state == S_DATA) && m_axi_rvalid && m_ready;

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state == S_AR) || (state == S_DATA);
  assign m_axi_arsize  = 3'd2;
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = (state == S_DATA) && m_ready;
  assign m_valid       = (state == S_DATA) && m_axi_rvalid;
  assign m_data        = m_axi_rdata;
  assign m_last        = m_valid && (rem_q == LEN_W'(1));

  // AR fields are loaded on the transition into S_AR so arvalid is already high in its first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      beat_cnt      <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_base;
            rem_q  <= cmd_words;
            err    <= 1'b0;
            if (cmd_words == '0) begin
              state <= S_DONE;
            end else begin
              state         <= S_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= cmd_base;
              m_axi_arlen   <= 8'(calc_blen(cmd_base[11:0], cmd_words) - 9'd1);
            end
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            beat_cnt      <= calc_blen(addr_q[11:0], rem_q);
            state         <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat) begin
            addr_q   <= next_addr;
            rem_q    <= next_rem;
            beat_cnt <= beat_cnt - 9'd1;
            // rlast must appear exactly on the counted final beat; counting never follows rlast.
            if ((beat_cnt == 9'd1) != m_axi_rlast) err <= 1'b1;
            if (beat_cnt == 9'd1) begin
              if (next_rem != '0) begin
                state         <= S_AR;
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= next_addr;
                m_axi_arlen   <= 8'(calc_blen(next_addr[11:0], next_rem) - 9'd1);
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_RD_DMA_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (state == S_IDLE && cmd_valid) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && !(&perf_cycles)) perf_cycles <= perf_cycles + 32'd1;
      if (state == S_DATA && m_axi_rvalid && !m_ready && !(&perf_stall))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_dma.sv
// Testbench for axi_rd_dma: behavioural AXI read slave plus a burst-splitting reference model.
module tb_axi_rd_dma;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic        m_axi_rvalid;
  logic        m_axi_rlast;
  logic        m_axi_rready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  axi_rd_dma dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .busy(busy), .done(done), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
    .m_axi_rready(m_axi_rready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [logic [31:0]];
  int ready_mode  = 0;
  int ar_wait_cfg = 0;
  bit bad_rlast   = 1'b0;

  logic [39:0] ar_q[$], exp_ar[$];
  logic [32:0] beat_q[$], exp_beat[$];
  int cyc = 0, acc_cnt = 0, accept_cyc = 0, done_cnt = 0, done_cyc = 0;
  int ar_unstable = 0, ar_stall = 0;
  int done_base = 0, acc_base = 0;
  bit ar_waiting = 1'b0;
  logic [39:0] prev_ar;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // Slave: one burst at a time, random rvalid gaps, configurable arready delay.
  initial begin
    bit ar_hs, r_hs, arv;
    logic [31:0] a_s;
    logic [7:0]  l_s;
    logic [39:0] sq[$];
    logic [39:0] cur;
    bit active;
    logic [31:0] beat_addr;
    int beats_left, ar_cnt;
    active = 1'b0; ar_cnt = 0; beats_left = 0; beat_addr = '0;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0; m_ready = 1'b1;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      arv   = m_axi_arvalid;
      a_s   = m_axi_araddr;
      l_s   = m_axi_arlen;
      @(posedge clk);
      #1;
      if (rst) begin
        sq.delete(); active = 1'b0; ar_cnt = 0; beats_left = 0;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      end else begin
        if (ar_hs) begin sq.push_back({a_s, l_s}); ar_cnt = 0; end
        else if (arv) ar_cnt++;
        if (r_hs) begin
          beat_addr += 32'd4; beats_left--;
          if (beats_left == 0) active = 1'b0;
          m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        end
        if (!active && sq.size() > 0) begin
          cur = sq.pop_front(); active = 1'b1;
          beat_addr = cur[39:8]; beats_left = int'(cur[7:0]) + 1;
        end
        if (active && !m_axi_rvalid && $urandom_range(2) != 0) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = mem_rd(beat_addr);
          m_axi_rlast  = (beats_left == 1) ^ bad_rlast;
        end
      end
      m_axi_arready = (ar_cnt >= ar_wait_cfg);
      m_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom_range(2) != 0) : 1'b0;
    end
  end

  // Monitor: records AR handshakes, stream beats, accepts and done pulses just before the edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin acc_cnt++; accept_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (m_axi_arvalid) begin
        if (ar_waiting && {m_axi_araddr, m_axi_arlen} != prev_ar) ar_unstable++;
        prev_ar = {m_axi_araddr, m_axi_arlen};
        ar_waiting = !m_axi_arready;
        if (m_axi_arready) ar_q.push_back({m_axi_araddr, m_axi_arlen});
        else ar_stall++;
      end else begin
        if (ar_waiting) ar_unstable++;
        ar_waiting = 1'b0;
      end
      if (m_valid && m_ready) beat_q.push_back({m_last, m_data});
    end else begin
      ar_waiting = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: walk the command in page/MAX_BURST-limited chunks.
  task automatic buildExpected(input logic [31:0] a, input int w);
    logic [31:0] p;
    int rem, room, b;
    exp_ar.delete();
    exp_beat.delete();
    p = a & ~32'd3;
    for (int i = 0; i < w; i++) exp_beat.push_back({1'(i == w - 1), mem_rd(p + 32'(4 * i))});
    rem = w;
    while (rem > 0) begin
      room = (4096 - int'(p % 4096)) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_ar.push_back({p, 8'(b - 1)});
      p += 32'(4 * b);
      rem -= b;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [15:0] w);
    ar_q.delete(); beat_q.delete();
    done_base = done_cnt; acc_base = acc_cnt; ar_unstable = 0; ar_stall = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_words = w;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("cmd_accepted", 64'(acc_cnt - acc_base), 64'd1);
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (done_cnt == done_base && n < 3000) begin tick(); n++; end
    checkOutput({tag, "_done"}, 64'(done_cnt - done_base), 64'd1);
    tick();
    checkOutput({tag, "_done_once"}, 64'(done_cnt - done_base), 64'd1);
  endtask

  task automatic checkTransfer(input string tag);
    checkOutput({tag, "_ar_count"}, 64'(ar_q.size()), 64'(exp_ar.size()));
    for (int i = 0; i < ar_q.size() && i < exp_ar.size(); i++)
      checkOutput({tag, "_ar"}, 64'(ar_q[i]), 64'(exp_ar[i]));
    checkOutput({tag, "_beat_count"}, 64'(beat_q.size()), 64'(exp_beat.size()));
    for (int i = 0; i < beat_q.size() && i < exp_beat.size(); i++)
      checkOutput({tag, "_beat"}, 64'(beat_q[i]), 64'(exp_beat[i]));
  endtask

  task automatic runCmd(input string tag, input logic [31:0] a, input int w, input bit exp_err);
    buildExpected(a, w);
    applyStimulus(a, 16'(w));
    waitDone(tag);
    checkTransfer(tag);
    checkOutput({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    logic [31:0] ra;
    int rw;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_words = '0;
    mem[32'h10] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    checkOutput("rst_araddr", 64'(m_axi_araddr), 64'd0);
    checkOutput("rst_arlen", 64'(m_axi_arlen), 64'd0);
    checkOutput("rst_rready", 64'(m_axi_rready), 64'd0);
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("arsize", 64'(m_axi_arsize), 64'd2);
    checkOutput("arburst", 64'(m_axi_arburst), 64'd1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();

    $display("[TB] single word");
    runCmd("single", 32'h10, 1, 1'b0);
    checkOutput("single_data", 64'(beat_q.size() > 0 ? beat_q[0] : 33'd0), 64'h1_1122_3344);

    $display("[TB] burst split");
    runCmd("split", 32'h100, 40, 1'b0);

    $display("[TB] 4 KB crossing");
    runCmd("cross4k", 32'hFF8, 6, 1'b0);

    $display("[TB] backpressure");
    ready_mode = 1; ar_wait_cfg = 5;
    runCmd("bp", 32'h300, 16, 1'b0);
    checkOutput("bp_ar_stable", 64'(ar_unstable), 64'd0);
    checkOutput("bp_ar_stall", 64'(ar_stall), 64'd5);
    ready_mode = 0; ar_wait_cfg = 0;

    $display("[TB] zero length and misaligned");
    runCmd("zero", 32'h203, 0, 1'b0);
    checkOutput("zero_done_latency", 64'(done_cyc - accept_cyc), 64'd2);
    runCmd("misalign", 32'h203, 1, 1'b0);

    $display("[TB] random commands");
    for (int k = 0; k < 5; k++) begin
      ra = (32'($urandom_range(1, 3)) << 12) - 32'(4 * $urandom_range(0, 24)) + 32'($urandom_range(0, 3));
      rw = int'($urandom_range(1, 48));
      ready_mode = 1; ar_wait_cfg = int'($urandom_range(0, 3));
      runCmd("rand", ra, rw, 1'b0);
      checkOutput("rand_ar_stable", 64'(ar_unstable), 64'd0);
    end
    ready_mode = 0; ar_wait_cfg = 0;

    $display("[TB] rlast error and clear");
    bad_rlast = 1'b1;
    runCmd("bad_rlast", 32'h40, 3, 1'b1);
    bad_rlast = 1'b0;
    runCmd("err_clear", 32'h40, 2, 1'b0);

    $display("[TB] async reset mid-DATA");
    ready_mode = 2;
    applyStimulus(32'h300, 16'd16);
    repeat (6) tick();
    checkOutput("pre_rst_busy", 64'(busy), 64'd1);
    checkOutput("pre_rst_araddr", 64'(m_axi_araddr), 64'h300);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_arvalid", 64'(m_axi_arvalid), 64'd0);
    checkOutput("arst_araddr", 64'(m_axi_araddr), 64'd0);
    checkOutput("arst_arlen", 64'(m_axi_arlen), 64'd0);
    checkOutput("arst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("arst_rready", 64'(m_axi_rready), 64'd0);
    checkOutput("arst_done", 64'(done), 64'd0);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick();
    runCmd("post_rst", 32'h10, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
